// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults and helpers for the shared-FIFO round-robin controller.
package fifo_ctrl_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int SKID_DEPTH     = 2;

  // Ceil-log2 index width, never below one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grant is the first requester at or after the pointer;
// the pointer moves past the granted requester whenever advance is set.
module rr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [IDX_W-1:0]   grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   ptr
);

  localparam logic [IDX_W:0] NUM_W = (IDX_W + 1)'(NUM_REQ);

  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [NUM_REQ-1:0] req_rot;
  logic [IDX_W-1:0]   offset;

  function automatic logic [IDX_W-1:0] wrap(input logic [IDX_W:0] s);
    return (s >= NUM_W) ? IDX_W'(s - NUM_W) : IDX_W'(s);
  endfunction

  // req_rot[k] is the request sitting k places after the pointer.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign req_rot[gi] = req[wrap((IDX_W + 1)'(gi) + {1'b0, ptr_reg})];
  end

  always_comb begin
    offset      = '0;
    grant_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        offset      = IDX_W'(k);
        grant_valid = 1'b1;
      end
    end
    grant    = wrap({1'b0, ptr_reg} + {1'b0, offset});
    ptr_next = advance ? wrap({1'b0, grant} + (IDX_W + 1)'(1)) : ptr_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_rr_ctrl.sv
// Shares one non-lookahead FIFO among NUM_REQ producers (round-robin writes)
// and turns its 1-cycle read latency into a valid/ready stream via a skid buffer.
module fifo_rr_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int  NUM_REQ    = DEF_NUM_REQ,
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int IDX_W      = idx_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  input  logic                          fifo_empty,
  output logic                          fifo_rd,
  input  logic [DATA_WIDTH-1:0]         fifo_dout,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              grant_id
);

  logic [IDX_W-1:0]      grant;
  logic                  grant_valid;
  logic [IDX_W-1:0]      unused_rr_ptr;
  logic [DATA_WIDTH-1:0] req_words [NUM_REQ];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req_valid),
    .advance     (fifo_wr),
    .grant       (grant),
    .grant_valid (grant_valid),
    .ptr         (unused_rr_ptr)
  );

  assign fifo_wr  = !rst && grant_valid && !fifo_full;
  assign grant_id = grant;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign req_ready[gi] = fifo_wr && (grant == IDX_W'(gi));
  end

  assign fifo_din = req_words[grant];

  logic                  inflight_reg;
  logic [1:0]            occ_reg, occ_next;
  logic                  head_reg;
  logic [DATA_WIDTH-1:0] skid_reg [SKID_DEPTH];
  logic                  pop;
  logic [2:0]            load, limit;

  assign out_valid = (occ_reg != 2'd0);
  assign out_data  = skid_reg[head_reg];
  assign pop       = out_valid && out_ready;

  // A new read may only be issued if its word is guaranteed a skid slot.
  assign load     = 3'(occ_reg) + 3'(inflight_reg);
  assign limit    = 3'(SKID_DEPTH) + 3'(pop);
  assign fifo_rd  = !rst && !fifo_empty && (load < limit);
  assign occ_next = occ_reg + 2'(inflight_reg) - 2'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_reg      <= '0;
      inflight_reg <= 1'b0;
      head_reg     <= 1'b0;
    end else begin
      occ_reg      <= occ_next;
      inflight_reg <= fifo_rd;
      head_reg     <= head_reg ^ pop;
    end
  end

  // Whenever a word lands, occ is at most 1, so the tail slot is head^occ[0].
  always_ff @(posedge clk) begin
    if (!rst && inflight_reg) skid_reg[head_reg ^ occ_reg[0]] <= fifo_dout;
  end

endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// Bench for fifo_rr_ctrl: a queue-based FIFO environment plus a reference
// model of grants and output-stream order, driven by directed and random steps.
module tb_fifo_rr_ctrl;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int IW    = 2;
  localparam int FDEPTH = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full, fifo_wr, fifo_empty, fifo_rd;
  logic [DW-1:0]   fifo_din, fifo_dout, out_data;
  logic            out_valid, out_ready;
  logic [IW-1:0]   grant_id;

  always #5 clk = ~clk;

  fifo_rr_ctrl #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_din   (fifo_din),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .grant_id   (grant_id)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  bit            rd_pending;
  bit            force_full;
  int            ref_ptr;
  logic [N-1:0]  last_ready;
  int            gq[$];
  int            pop_cyc[$];
  logic [DW-1:0] pop_dat[$];
  int            first_rd;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic [7:0]    pre [8];
  int            seqn [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic update_flags();
    fifo_empty = (fifo_q.size() == 0);
    fifo_full  = force_full || (fifo_q.size() >= FDEPTH);
  endtask

  task automatic step();
    int            exp_g, landed;
    bit            found, exp_wr, exp_rd, pop_m, wr_s, rd_s;
    logic [DW-1:0] din_s, w;
    update_flags();
    #1;
    exp_g = 0; exp_wr = 0; found = 0;
    if (!rst && req_valid != '0 && !fifo_full) begin
      exp_wr = 1;
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(ref_ptr + k) % N]) begin
          exp_g = (ref_ptr + k) % N;
          found = 1;
        end
      end
    end
    chk("fifo_wr", 64'(fifo_wr), 64'(exp_wr));
    chk("req_ready", 64'(req_ready), exp_wr ? (64'd1 << exp_g) : 64'd0);
    if (exp_wr) begin
      chk("grant_id", 64'(grant_id), 64'(exp_g));
      chk("fifo_din", 64'(fifo_din), 64'(req_data[exp_g*DW +: DW]));
    end
    landed = exp_q.size() - int'(rd_pending);
    pop_m  = (landed != 0) && out_ready;
    if (rst) begin
      chk("fifo_rd_rst", 64'(fifo_rd), 64'd0);
    end else begin
      exp_rd = !fifo_empty && ((landed + int'(rd_pending) - int'(pop_m)) < 2);
      chk("fifo_rd", 64'(fifo_rd), 64'(exp_rd));
      chk("out_valid", 64'(out_valid), 64'(landed != 0));
      if (landed != 0) chk("out_data", 64'(out_data), 64'(exp_q[0]));
      if (prev_stall) chk("stall_hold", 64'(out_data), 64'(prev_data));
    end
    wr_s = fifo_wr; din_s = fifo_din; rd_s = fifo_rd; last_ready = req_ready;
    if (wr_s) gq.push_back(int'(grant_id));
    if (rd_s && first_rd < 0) first_rd = cyc;
    if (!rst && out_valid && out_ready) begin
      pop_cyc.push_back(cyc);
      pop_dat.push_back(out_data);
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev_data  = out_data;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      fifo_q.delete(); exp_q.delete();
      rd_pending = 0; ref_ptr = 0; prev_stall = 0;
    end else begin
      if (pop_m) void'(exp_q.pop_front());
      rd_pending = 0;
      fifo_dout  = $urandom;
      if (rd_s && fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
        fifo_dout = w;
        exp_q.push_back(w);
        rd_pending = 1;
      end
      if (wr_s) fifo_q.push_back(din_s);
      if (exp_wr) ref_ptr = (exp_g + 1) % N;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    req_valid = '0; out_ready = 1'b1; force_full = 0;
    n = 0;
    while ((fifo_q.size() + exp_q.size()) != 0 && n < 80) begin
      step();
      n++;
    end
    chk("drained", 64'(fifo_q.size() + exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(pre[i]));
    pop_cyc.delete(); pop_dat.delete(); first_rd = -1;
  endtask

  initial begin
    int n, base;
    pre = '{8'h5A, 8'hF6, 8'h09, 8'hC4, 8'h81, 8'hE2, 8'hA0, 8'h7A};
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
    force_full = 0; fifo_dout = '0; rd_pending = 0; ref_ptr = 0;
    first_rd = -1; prev_stall = 0; prev_data = '0; last_ready = '0;
    update_flags();
    @(negedge clk);

    // Reset, then idle
    step(); step();
    rst = 1'b0;
    repeat (20) step();

    // All requesters continuously valid with their own sequences
    for (int i = 0; i < N; i++) seqn[i] = 0;
    req_valid = '1; out_ready = 1'b1;
    gq.delete();
    n = 0;
    while (gq.size() < 16 && n < 40) begin
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(8'hA0 + i*16 + seqn[i]);
      step();
      for (int i = 0; i < N; i++) if (last_ready[i]) seqn[i]++;
      n++;
    end
    chk("rr_writes", 64'(gq.size()), 64'd16);
    for (int k = 0; k < gq.size(); k++) chk("rr_order", 64'(gq[k]), 64'(k % N));
    drain();

    // Only requester 2: first write moves pointer to 3, second still grants 2
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 32'h0000_2222;
    step();
    req_data[2*DW +: DW] = 32'h0000_2223;
    gq.delete();
    step();
    chk("grant_from_ptr3", 64'(gq.size() == 1 ? gq[0] : -1), 64'd2);

    // FIFO full for 5 cycles with requester 1 waiting
    req_valid = 4'b0010;
    req_data[1*DW +: DW] = 32'h0000_1111;
    force_full = 1;
    gq.delete();
    repeat (5) begin
      step();
      chk("full_no_ready", 64'(last_ready), 64'd0);
    end
    force_full = 0;
    step();
    chk("after_full_grant", 64'(gq.size() == 1 ? gq[0] : -1), 64'd1);
    drain();

    // Preloaded FIFO, consumer always ready: latency and throughput
    do_reset();
    preload();
    out_ready = 1'b1;
    repeat (14) step();
    chk("lat_pops", 64'(pop_cyc.size()), 64'd8);
    for (int k = 0; k < pop_cyc.size(); k++) begin
      chk("lat_cycle", 64'(pop_cyc[k]), 64'(first_rd + 2 + k));
      chk("lat_data", 64'(pop_dat[k]), 64'(pre[k]));
    end

    // Preloaded FIFO, consumer ready one cycle in three
    do_reset();
    preload();
    n = 0;
    while (pop_dat.size() < 8 && n < 200) begin
      out_ready = ($urandom_range(0, 2) == 0);
      step();
      n++;
    end
    chk("stall_pops", 64'(pop_dat.size()), 64'd8);
    for (int k = 0; k < pop_dat.size(); k++) chk("stall_data", 64'(pop_dat[k]), 64'(pre[k]));

    // Reset in the middle of a stream
    do_reset();
    preload();
    out_ready = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    step();

    // Random traffic on both sides
    base = cyc;
    req_valid = '0;
    while (cyc - base < 400) begin
      for (int i = 0; i < N; i++) begin
        if (last_ready[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = $urandom;
        end
      end
      force_full = ($urandom_range(0, 4) == 0);
      out_ready  = ($urandom_range(0, 1) == 1);
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_rr_ctrl.md
Name: fifo_rr_ctrl

Overview:
Controller that shares one non-lookahead FIFO (ports full/wr/din, empty/rd/dout; dout valid the cycle after rd) among NUM_REQ producers.
- Write side: producers are arbitrated round-robin onto the FIFO write port.
- Read side: the FIFO's 1-cycle read latency is sequenced into a full-throughput valid/ready output stream through a 2-entry skid buffer.
- Sits directly beside the fifo instance; producers and consumer never touch the FIFO ports themselves.

Parameters:
NUM_REQ, 4, number of write requesters (2..16)
DATA_WIDTH, 32, word width; equals the FIFO din/dout width
IDX_W, $clog2(NUM_REQ), requester index width (derived, not overridable)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester word valid
req_data  input  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  one-hot (or zero) accept strobe
fifo_full  input  1  FIFO full flag
fifo_wr  output  1  FIFO write enable
fifo_din  output  DATA_WIDTH  FIFO write data
fifo_empty  input  1  FIFO empty flag
fifo_rd  output  1  FIFO read enable
fifo_dout  input  DATA_WIDTH  FIFO read data, valid cycle after fifo_rd
out_valid  output  1  output word valid
out_data  output  DATA_WIDTH  output word
out_ready  input  1  consumer accept
grant_id  output  IDX_W  index of the requester written this cycle (don't-care when fifo_wr=0)

Behaviour:
- Reset state: rr_ptr=0, skid occupancy=0, inflight=0.
- Reset outputs: out_valid=0, fifo_rd=0, fifo_wr=0, req_ready=0.
- Reset mid-operation: an in-flight read word is discarded; the FIFO is reset by the same rst.

Write arbitration (combinational from registered rr_ptr):
- grant = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
- fifo_wr = |req_valid && !fifo_full.
- fifo_din = req_data of grant; grant_id = grant.
- req_ready[grant] = fifo_wr; all other bits of req_ready are 0.
- On fifo_wr: rr_ptr <= (grant+1) mod NUM_REQ. Otherwise rr_ptr holds.
- fifo_full=1: no write, req_ready=0, rr_ptr unchanged.
- Requester handshake: keep valid/data stable until ready. A requester that drops valid before being granted loses no state.
- Fairness: with all requesters continuously valid, each is granted exactly once per NUM_REQ writes.

Read sequencing:
- inflight <= fifo_rd (1-cycle read latency).
- When inflight=1, fifo_dout is pushed into the skid buffer that cycle.
- pop = out_valid && out_ready.
- fifo_rd = !fifo_empty && (occ + inflight - pop) < 2. Occupancy can therefore never exceed 2, so no overflow is possible.
- out_valid = (occ != 0); out_data = buffer head (oldest word).
- Push and pop in the same cycle: occ is unchanged, and order is preserved.
- Steady state with out_ready=1 and FIFO non-empty: one word per cycle.
- First word latency: fifo_rd in cycle N, out_valid in cycle N+2.
- out_data must hold while out_valid=1 and out_ready=0.
- fifo_empty asserting while inflight=1: the in-flight word is still captured.
- Write and read sides are independent; simultaneous fifo_wr and fifo_rd is legal.

Decomposition:
- Package fifo_ctrl_pkg: default NUM_REQ/DATA_WIDTH localparams, SKID_DEPTH=2, and a clog2-style index-width function.
- Sub-module rr_arbiter (NUM_REQ): inputs req/advance, outputs grant, grant_valid, registered pointer.
- The skid buffer stays inline (two registers plus occ and a head bit).

Test Plan:
- Reset, then all req_valid=0 and fifo_empty=1 -> fifo_wr=0, fifo_rd=0, out_valid=0 for 20 cycles.
- All 4 requesters valid continuously, each sending its own sequence (req i sends 8'hA0+i*16+n) -> grants 0,1,2,3,0,...; per-requester order preserved in FIFO.
- Only req 2 valid after rr_ptr=3 -> grant_id=2 next write; rr_ptr becomes 3.
- fifo_full held 5 cycles with req 1 valid -> req_ready=0, fifo_wr=0; first write after deassert goes to req 1.
- FIFO preloaded with 5A,F6,09,C4,81,E2,A0,7A, out_ready=1 -> fifo_rd cycle N, out_data 5A at N+2, then one word per cycle, exact order.
- Same preload, out_ready random 1-in-3 -> no loss or duplication, occ ≤2, out_data stable while stalled; rst mid-stream -> out_valid=0 next cycle.
